uart_rx_param: RTL and testbench

UART_RX_PARAM -- requirements
Module: uart_rx_param

---
 rtl/uart_rx_param.sv | 215 +++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_rx_param
// Description : Oversampled UART receiver with optional parity, 1/2 stop
//               bits, held-word valid/ready output and break detection.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_param #(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    parameter int OVERSAMPLE  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 braud,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] out_rx,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int                  c_TICK_W    = $clog2(OVERSAMPLE);
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(OVERSAMPLE - 1);
    localparam logic [c_TICK_W-1:0] c_TICK_MID  = c_TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]          c_DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]          c_STOP_LAST = 4'(STOP_BITS - 1);

    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_START  = 3'd1;
    localparam logic [2:0] c_S_DATA   = 3'd2;
    localparam logic [2:0] c_S_PARITY = 3'd3;
    localparam logic [2:0] c_S_STOP   = 3'd4;
    localparam logic [2:0] c_S_BREAK  = 3'd5;

    logic                 r_rx_meta;
    logic                 r_rx_sync;
    logic [2:0]           r_state;
    logic [c_TICK_W-1:0]  r_tick;
    logic [3:0]           r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_bad;
    logic                 r_frame_bad;
    logic                 r_done;
    logic [DATA_BITS-1:0] r_out_rx;
    logic                 r_valid;
    logic                 r_parity_err;
    logic                 r_frame_err;
    logic                 r_overrun;

    logic [2:0]           w_state_nxt;
    logic [c_TICK_W-1:0]  w_tick_nxt;
    logic [3:0]           w_bit_nxt;
    logic                 w_frame_start;
    logic                 w_sample_data;
    logic                 w_sample_par;
    logic                 w_sample_stop;
    logic                 w_last_stop;
    logic                 w_par_calc;

    // Counters and state only move on braud clocks; everything else holds.
    always_comb begin
        w_state_nxt   = r_state;
        w_tick_nxt    = r_tick;
        w_bit_nxt     = r_bit;
        w_frame_start = 1'b0;
        w_sample_data = 1'b0;
        w_sample_par  = 1'b0;
        w_sample_stop = 1'b0;
        w_last_stop   = 1'b0;
        if (braud) begin
            case (r_state)
                c_S_IDLE: begin
                    if (!r_rx_sync) begin
                        w_state_nxt = c_S_START;
                        w_tick_nxt  = '0;
                    end
                end
                c_S_START: begin
                    if (r_tick == c_TICK_MID) begin
                        w_tick_nxt = '0;
                        if (!r_rx_sync) begin
                            w_state_nxt   = c_S_DATA;
                            w_bit_nxt     = '0;
                            w_frame_start = 1'b1;
                        end else begin
                            w_state_nxt = c_S_IDLE;
                        end
                    end else begin
                        w_tick_nxt = r_tick + c_TICK_W'(1);
                    end
                end
                c_S_DATA: begin
                    if (r_tick == c_TICK_LAST) begin
                        w_tick_nxt    = '0;
                        w_sample_data = 1'b1;
                        if (r_bit == c_DATA_LAST) begin
                            w_bit_nxt   = '0;
                            w_state_nxt = (PARITY_MODE != 0) ? c_S_PARITY : c_S_STOP;
                        end else begin
                            w_bit_nxt = r_bit + 4'd1;
                        end
                    end else begin
                        w_tick_nxt = r_tick + c_TICK_W'(1);
                    end
                end
                c_S_PARITY: begin
                    if (r_tick == c_TICK_LAST) begin
                        w_tick_nxt   = '0;
                        w_sample_par = 1'b1;
                        w_state_nxt  = c_S_STOP;
                    end else begin
                        w_tick_nxt = r_tick + c_TICK_W'(1);
                    end
                end
                c_S_STOP: begin
                    if (r_tick == c_TICK_LAST) begin
                        w_tick_nxt    = '0;
                        w_sample_stop = 1'b1;
                        if (r_bit == c_STOP_LAST) begin
                            w_bit_nxt   = '0;
                            w_last_stop = 1'b1;
                            w_state_nxt = r_rx_sync ? c_S_IDLE : c_S_BREAK;
                        end else begin
                            w_bit_nxt = r_bit + 4'd1;
                        end
                    end else begin
                        w_tick_nxt = r_tick + c_TICK_W'(1);
                    end
                end
                c_S_BREAK: begin
                    if (r_rx_sync) begin
                        w_state_nxt = c_S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = c_S_IDLE;
                    w_tick_nxt  = '0;
                    w_bit_nxt   = '0;
                end
            endcase
        end
    end

    // Odd mode flags an error when the data+parity XOR is 0, even mode when 1.
    assign w_par_calc = (^r_shift) ^ r_rx_sync;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rx_meta    <= 1'b1;
            r_rx_sync    <= 1'b1;
            r_state      <= c_S_IDLE;
            r_tick       <= '0;
            r_bit        <= '0;
            r_shift      <= '0;
            r_par_bad    <= 1'b0;
            r_frame_bad  <= 1'b0;
            r_done       <= 1'b0;
            r_out_rx     <= '0;
            r_valid      <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
            r_state   <= w_state_nxt;
            r_tick    <= w_tick_nxt;
            r_bit     <= w_bit_nxt;
            if (w_frame_start) begin
                r_par_bad   <= 1'b0;
                r_frame_bad <= 1'b0;
            end
            if (w_sample_data) begin
                r_shift <= {r_rx_sync, r_shift[DATA_BITS-1:1]};
            end
            if (w_sample_par) begin
                r_par_bad <= (PARITY_MODE == 2) ? ~w_par_calc : w_par_calc;
            end
            if (w_sample_stop && !r_rx_sync) begin
                r_frame_bad <= 1'b1;
            end
            // The word is committed one clk after the final stop sample so the
            // last stop-bit error is already folded into r_frame_bad.
            r_done    <= w_last_stop;
            r_overrun <= 1'b0;
            if (r_done) begin
                if (!r_valid || out_ready) begin
                    r_out_rx     <= r_shift;
                    r_parity_err <= r_par_bad;
                    r_frame_err  <= r_frame_bad;
                    r_valid      <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_rx      = r_out_rx;
    assign out_valid   = r_valid;
    assign parity_err  = r_parity_err;
    assign frame_err   = r_frame_err;
    assign overrun_err = r_overrun;
    assign busy        = (r_state != c_S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_param
// Description : Randomized self-checking bench for uart_rx_param (default
//               8N1 instance and an 8E2 instance).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_param;

    localparam int c_OS = 16;

    logic       clk       = 1'b0;
    logic       reset     = 1'b0;
    logic       braud     = 1'b0;
    logic       rx_d      = 1'b1;
    logic       rx_p      = 1'b1;
    logic       out_ready = 1'b1;

    logic [7:0] out_rx_d, out_rx_p;
    logic       valid_d, valid_p, perr_d, perr_p, ferr_d, ferr_p;
    logic       ovr_d, ovr_p, busy_d, busy_p;

    int n_cmp = 0;
    int n_bad = 0;

    uart_rx_param #(.DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .OVERSAMPLE(c_OS)) u_dut_d (
        .clk(clk), .reset(reset), .braud(braud), .rx(rx_d), .out_rx(out_rx_d),
        .out_valid(valid_d), .out_ready(out_ready), .parity_err(perr_d),
        .frame_err(ferr_d), .overrun_err(ovr_d), .busy(busy_d)
    );

    uart_rx_param #(.DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(2), .OVERSAMPLE(c_OS)) u_dut_p (
        .clk(clk), .reset(reset), .braud(braud), .rx(rx_p), .out_rx(out_rx_p),
        .out_valid(valid_p), .out_ready(out_ready), .parity_err(perr_p),
        .frame_err(ferr_p), .overrun_err(ovr_p), .busy(busy_p)
    );

    always #5 clk = ~clk;

    // Irregular oversample tick: exercises the braud=0 hold behaviour throughout.
    initial begin
        forever begin
            @(posedge clk);
            #1 braud = ($urandom_range(0, 2) == 0);
        end
    end

    // Word monitors: a word is recorded on every valid&&ready handshake.
    logic [9:0] got_d[$];
    logic [9:0] got_p[$];
    int         ovr_cnt_d = 0, ovr_cnt_p = 0, vrise_d = 0, vrise_p = 0;
    logic       vprev_d = 1'b0, vprev_p = 1'b0;

    always @(negedge clk) begin
        if (valid_d && out_ready) got_d.push_back({perr_d, ferr_d, out_rx_d});
        if (valid_p && out_ready) got_p.push_back({perr_p, ferr_p, out_rx_p});
        if (ovr_d) ovr_cnt_d++;
        if (ovr_p) ovr_cnt_p++;
        if (valid_d && !vprev_d) vrise_d++;
        if (valid_p && !vprev_p) vrise_p++;
        vprev_d = valid_d;
        vprev_p = valid_p;
    end

    // Reference: what a receiver of this frame format must report.
    function automatic logic [9:0] model_word(input logic [7:0] d, input int mode,
                                              input logic pbit, input logic [1:0] stop_low,
                                              input int nstop);
        int ones = 0;
        logic pe, fe;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        ones += int'(pbit);
        if (mode == 0)      pe = 1'b0;
        else if (mode == 1) pe = (ones % 2 == 1);
        else                pe = (ones % 2 == 0);
        fe = (nstop == 2) ? (stop_low != 2'b00) : stop_low[0];
        return {pe, fe, d};
    endfunction

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (braud !== 1'b1) @(posedge clk);
        end
        #2;
    endtask

    task automatic set_rx(input int sel, input logic v);
        if (sel == 1) rx_p = v;
        else          rx_d = v;
    endtask

    task automatic send_frame(input int sel, input logic [7:0] d, input logic pbit,
                              input logic [1:0] stop_low, input bit idle_after);
        set_rx(sel, 1'b0);
        ticks(c_OS);
        for (int i = 0; i < 8; i++) begin
            set_rx(sel, d[i]);
            ticks(c_OS);
        end
        if (sel == 1) begin
            set_rx(sel, pbit);
            ticks(c_OS);
        end
        for (int s = 0; s < ((sel == 1) ? 2 : 1); s++) begin
            set_rx(sel, !stop_low[s]);
            ticks(c_OS);
        end
        if (idle_after) begin
            set_rx(sel, 1'b1);
            ticks(2);
        end
    endtask

    task automatic wait_idle(input int sel, input string tag);
        int n = 0;
        while (((sel == 1) ? busy_p : busy_d) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (n >= 4000) begin
            n_bad++;
            $display("FAIL %s_idle_timeout: busy still %b, required 0", tag, (sel == 1) ? busy_p : busy_d);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({out_rx_d, valid_d, perr_d, ferr_d, ovr_d, busy_d} !== 13'h0) begin
            n_bad++;
            $display("FAIL reset_d: got %h required 0", {out_rx_d, valid_d, perr_d, ferr_d, ovr_d, busy_d});
        end
        n_cmp++;
        if ({out_rx_p, valid_p, perr_p, ferr_p, ovr_p, busy_p} !== 13'h0) begin
            n_bad++;
            $display("FAIL reset_p: got %h required 0", {out_rx_p, valid_p, perr_p, ferr_p, ovr_p, busy_p});
        end
        @(posedge clk);
        #2 reset = 1'b1;
        repeat (40) @(negedge clk);
        n_cmp++;
        if ({out_rx_d, valid_d, perr_d, ferr_d, ovr_d, busy_d, vrise_d} !== 45'h0) begin
            n_bad++;
            $display("FAIL post_reset_quiet: got %h required 0", {out_rx_d, valid_d, perr_d, ferr_d, ovr_d, busy_d});
        end
    endtask

    task automatic test_basic;
        int b = got_d.size();
        int v = vrise_d;
        send_frame(0, 8'hA5, 1'b0, 2'b00, 1'b1);
        wait_idle(0, "basic");
        n_cmp++;
        if (vrise_d - v !== 1) begin
            n_bad++;
            $display("FAIL basic_valid_pulses: got %0d required 1", vrise_d - v);
        end
        n_cmp++;
        if (got_d.size() != b + 1 || got_d[b] !== 10'h0A5) begin
            n_bad++;
            $display("FAIL basic_word: got %h (count %0d) required 0a5", (got_d.size() > b) ? got_d[b] : 10'h3ff, got_d.size() - b);
        end
    endtask

    task automatic test_glitch;
        int v = vrise_d;
        set_rx(0, 1'b0);
        ticks(4);
        n_cmp++;
        if (busy_d !== 1'b1) begin
            n_bad++;
            $display("FAIL glitch_busy_start: got %b required 1", busy_d);
        end
        set_rx(0, 1'b1);
        ticks(c_OS);
        n_cmp++;
        if (busy_d !== 1'b0 || valid_d !== 1'b0 || vrise_d != v) begin
            n_bad++;
            $display("FAIL glitch_return: busy %b valid %b pulses %0d, required 0 0 0", busy_d, valid_d, vrise_d - v);
        end
    endtask

    task automatic test_random_default;
        logic [9:0] exp[$];
        int b = got_d.size();
        for (int i = 0; i < 6; i++) begin
            logic [7:0] d = 8'($urandom);
            logic [1:0] sl = {1'b0, ($urandom_range(0, 3) == 0)};
            exp.push_back(model_word(d, 0, 1'b0, sl, 1));
            send_frame(0, d, 1'b0, sl, 1'b1);
        end
        wait_idle(0, "rand_d");
        n_cmp++;
        if (got_d.size() != b + 6) begin
            n_bad++;
            $display("FAIL rand_d_count: got %0d required 6", got_d.size() - b);
        end
        for (int i = 0; i < 6 && (b + i) < got_d.size(); i++) begin
            n_cmp++;
            if (got_d[b+i] !== exp[i]) begin
                n_bad++;
                $display("FAIL rand_d_word%0d: got %h required %h", i, got_d[b+i], exp[i]);
            end
        end
    endtask

    task automatic test_parity;
        int b = got_p.size();
        send_frame(1, 8'h3C, 1'b1, 2'b00, 1'b1);
        send_frame(1, 8'h3C, 1'b0, 2'b00, 1'b1);
        wait_idle(1, "parity");
        n_cmp++;
        if (got_p.size() != b + 2) begin
            n_bad++;
            $display("FAIL parity_count: got %0d required 2", got_p.size() - b);
        end else begin
            n_cmp++;
            if (got_p[b] !== 10'h23C) begin
                n_bad++;
                $display("FAIL parity_bad_bit: got %h required 23c", got_p[b]);
            end
            n_cmp++;
            if (got_p[b+1] !== 10'h03C) begin
                n_bad++;
                $display("FAIL parity_good_bit: got %h required 03c", got_p[b+1]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [9:0] exp[$];
        int b = got_p.size();
        for (int i = 0; i < 6; i++) begin
            logic [7:0] d  = 8'($urandom);
            logic       pb = 1'($urandom);
            logic [1:0] sl = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            exp.push_back(model_word(d, 1, pb, sl, 2));
            send_frame(1, d, pb, sl, 1'b1);
        end
        wait_idle(1, "b2b");
        n_cmp++;
        if (got_p.size() != b + 6) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d required 6", got_p.size() - b);
        end
        for (int i = 0; i < 6 && (b + i) < got_p.size(); i++) begin
            n_cmp++;
            if (got_p[b+i] !== exp[i]) begin
                n_bad++;
                $display("FAIL b2b_word%0d: got %h required %h", i, got_p[b+i], exp[i]);
            end
        end
    endtask

    task automatic test_break;
        int b = got_d.size();
        logic [7:0] d = 8'($urandom);
        logic [9:0] e = model_word(d, 0, 1'b0, 2'b01, 1);
        send_frame(0, d, 1'b0, 2'b01, 1'b0);
        ticks(3 * c_OS);
        n_cmp++;
        if (busy_d !== 1'b1) begin
            n_bad++;
            $display("FAIL break_hold_busy: got %b required 1", busy_d);
        end
        n_cmp++;
        if (got_d.size() != b + 1 || got_d[b] !== e) begin
            n_bad++;
            $display("FAIL break_word: got %h (count %0d) required %h", (got_d.size() > b) ? got_d[b] : 10'h3ff, got_d.size() - b, e);
        end
        set_rx(0, 1'b1);
        ticks(c_OS);
        n_cmp++;
        if (busy_d !== 1'b0 || got_d.size() != b + 1) begin
            n_bad++;
            $display("FAIL break_release: busy %b count %0d, required 0 1", busy_d, got_d.size() - b);
        end
        send_frame(0, 8'h96, 1'b0, 2'b00, 1'b1);
        wait_idle(0, "break_next");
        n_cmp++;
        if (got_d.size() != b + 2 || got_d[b+1] !== 10'h096) begin
            n_bad++;
            $display("FAIL break_next_word: got %h (count %0d) required 096", (got_d.size() > b + 1) ? got_d[b+1] : 10'h3ff, got_d.size() - b);
        end
    endtask

    task automatic test_overrun;
        int b = got_d.size();
        int o = ovr_cnt_d;
        out_ready = 1'b0;
        send_frame(0, 8'h11, 1'b0, 2'b00, 1'b1);
        send_frame(0, 8'h22, 1'b0, 2'b00, 1'b1);
        wait_idle(0, "overrun");
        n_cmp++;
        if (valid_d !== 1'b1 || out_rx_d !== 8'h11) begin
            n_bad++;
            $display("FAIL overrun_hold: valid %b data %h, required 1 11", valid_d, out_rx_d);
        end
        n_cmp++;
        if (ovr_cnt_d - o != 1) begin
            n_bad++;
            $display("FAIL overrun_pulse: got %0d clks required 1", ovr_cnt_d - o);
        end
        @(posedge clk);
        #2 out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (valid_d !== 1'b0 || out_rx_d !== 8'h11) begin
            n_bad++;
            $display("FAIL overrun_drain: valid %b data %h, required 0 11", valid_d, out_rx_d);
        end
        n_cmp++;
        if (got_d.size() != b + 1 || got_d[b] !== 10'h011) begin
            n_bad++;
            $display("FAIL overrun_word: got %h (count %0d) required 011", (got_d.size() > b) ? got_d[b] : 10'h3ff, got_d.size() - b);
        end
    endtask

    task automatic test_reset_mid;
        int b = got_d.size();
        int o = ovr_cnt_d;
        set_rx(0, 1'b0);
        ticks(c_OS);
        set_rx(0, 1'b1);
        ticks(4 * c_OS + c_OS / 2);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (busy_d !== 1'b0 || valid_d !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_state: busy %b valid %b, required 0 0", busy_d, valid_d);
        end
        #1 reset = 1'b1;
        ticks(2 * c_OS);
        send_frame(0, 8'h5A, 1'b0, 2'b00, 1'b1);
        wait_idle(0, "reset_mid");
        n_cmp++;
        if (got_d.size() != b + 1 || got_d[b] !== 10'h05A || ovr_cnt_d != o) begin
            n_bad++;
            $display("FAIL reset_mid_word: got %h (count %0d, overruns %0d) required 05a 1 0", (got_d.size() > b) ? got_d[b] : 10'h3ff, got_d.size() - b, ovr_cnt_d - o);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_glitch;
        test_random_default;
        test_parity;
        test_back_to_back;
        test_break;
        test_overrun;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
